// File: rtl/sync_2t_fifo_pkg.sv
// Shared constants and helpers for the write-buffered sync FIFO.
// Holds buffer depths and the count-width helper.
package sync_2t_fifo_pkg;

  localparam int WBUF_DEPTH = 4;
  localparam int OSTG_DEPTH = 2;

  // A count that must reach `depth` needs clog2(depth)+1 bits.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/single_port_RAM.sv
// Single-port RAM with a registered read port (1-cycle latency).
// Ports: clk, we, addr, din in; dout out.
module single_port_RAM #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/sync_2t_reg_stage.sv
// Small register FIFO: async active-low reset, sync clear.
// Ports: clk, rstn, clear, push, pop, din in; dout, count, full, empty out.
module sync_2t_reg_stage
  import sync_2t_fifo_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(DEPTH),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d        = nxt(wptr_q);
    end
    if (pop) rptr_d = nxt(rptr_q);
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sync_2t_wbuf_fifo.sv
// Sync FIFO on one single-port RAM: reads own the port, a write buffer
// commits in idle cycles, a 2-entry output stage hides read latency.
// Ports: clk, rstn, in_* (valid/ready), out_* (valid/ready), clear, count.
module sync_2t_wbuf_fifo
  import sync_2t_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256,
  localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear,
  output logic [LB_FIFO_DEPTH:0] count
);

  localparam int CW  = cnt_width(FIFO_DEPTH);
  localparam int WCW = cnt_width(WBUF_DEPTH);
  localparam int SCW = cnt_width(OSTG_DEPTH);
  localparam int AW  = LB_FIFO_DEPTH;

  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] mem_count_q, mem_count_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_inflight_q, rd_inflight_d;

  logic [DATA_WIDTH-1:0] wbuf_head;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [WCW-1:0]        wbuf_cnt;
  logic                  wbuf_full, wbuf_empty;
  logic [SCW-1:0]        stage_cnt;
  logic                  stage_full, stage_empty;

  logic          in_exec, out_exec;
  logic [2:0]    occ;
  logic          room, rd_want, commit, rd_issue;
  logic [AW-1:0] mem_addr;

  assign in_ready  = rstn & !wbuf_full
                   & (count_q < CW'(FIFO_DEPTH)) & !clear;
  assign out_valid = !stage_empty;
  assign in_exec   = in_valid & in_ready;
  assign out_exec  = out_valid & out_ready;

  // Stage slots already spoken for after this cycle's pop.
  assign occ      = 3'(stage_cnt) + 3'(rd_inflight_q) - 3'(out_exec);
  assign room     = (occ < 3'd2);
  assign rd_want  = (mem_count_q != '0) & room;
  // A full write buffer steals the port so writes never starve.
  assign commit   = !wbuf_empty & (wbuf_full | !rd_want);
  assign rd_issue = rd_want & !commit;
  assign mem_addr = commit ? waddr_q : raddr_q;

  always_comb begin
    waddr_d       = waddr_q;
    raddr_d       = raddr_q;
    mem_count_d   = mem_count_q + CW'(commit) - CW'(rd_issue);
    count_d       = count_q + CW'(in_exec) - CW'(out_exec);
    rd_inflight_d = rd_issue;
    if (commit)   waddr_d = waddr_q + AW'(1);
    if (rd_issue) raddr_d = raddr_q + AW'(1);
    if (clear) begin
      waddr_d       = '0;
      raddr_d       = '0;
      mem_count_d   = '0;
      count_d       = '0;
      rd_inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr_q       <= '0;
      raddr_q       <= '0;
      mem_count_q   <= '0;
      count_q       <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      waddr_q       <= waddr_d;
      raddr_q       <= raddr_d;
      mem_count_q   <= mem_count_d;
      count_q       <= count_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  assign count = count_q;

  sync_2t_reg_stage #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_wbuf (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (in_exec),
    .pop   (commit),
    .din   (in_data),
    .dout  (wbuf_head),
    .count (wbuf_cnt),
    .full  (wbuf_full),
    .empty (wbuf_empty)
  );

  single_port_RAM #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk  (clk),
    .we   (commit),
    .addr (mem_addr),
    .din  (wbuf_head),
    .dout (ram_dout)
  );

  sync_2t_reg_stage #(
    .DEPTH (OSTG_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ostg (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (rd_inflight_q),
    .pop   (out_exec),
    .din   (ram_dout),
    .dout  (out_data),
    .count (stage_cnt),
    .full  (stage_full),
    .empty (stage_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(commit && rd_issue));
      assert (mem_count_q <= CW'(FIFO_DEPTH));
      assert (stage_cnt <= SCW'(OSTG_DEPTH));
      assert (count_q == CW'(wbuf_cnt) + mem_count_q
                       + CW'(rd_inflight_q) + CW'(stage_cnt));
      assert (!(stage_full && rd_inflight_q && !out_exec));
    end
  end
`endif

endmodule

// File: tb/tb_sync_2t_wbuf_fifo.sv
// Self-checking bench for sync_2t_wbuf_fifo (FIFO_DEPTH=8).
// Cycle table, hand sequences, and random traffic vs a queue model.
module tb_sync_2t_wbuf_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       clear;
  logic [3:0] count;

  int n_cmp;
  int n_bad;
  logic [7:0] q [$];

  sync_2t_wbuf_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clear     (clear),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample, update model, wait posedge.
  task automatic step(
    input  logic       iv,
    input  logic [7:0] id,
    input  logic       ordy,
    input  logic       clr,
    output logic       s_ov,
    output logic [7:0] s_od,
    output logic       s_ir,
    output logic [3:0] s_cnt
  );
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clear     = clr;
    #1;
    s_ov  = out_valid;
    s_od  = out_data;
    s_ir  = in_ready;
    s_cnt = count;
    chk("count_model", int'(count), q.size());
    if (q.size() == 0) chk("empty_no_valid", int'(out_valid), 0);
    if (q.size() == 8) chk("full_no_ready", int'(in_ready), 0);
    if (out_valid && out_ready && !clr) begin
      if (q.size() == 0) chk("pop_on_empty", 1, 0);
      else chk("order", int'(out_data), int'(q.pop_front()));
    end
    if (in_valid && in_ready) q.push_back(in_data);
    if (clr) q.delete();
    @(posedge clk);
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    int         ecnt;
    logic       eov;
    logic [7:0] eod;
    logic       eir;
  } vec_t;

  vec_t tbl [26];

  logic       s_ov;
  logic [7:0] s_od;
  logic       s_ir;
  logic [3:0] s_cnt;

  task automatic idle(input int n, input logic ordy);
    logic       a;
    logic [7:0] b;
    logic       c;
    logic [3:0] d;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, a, b, c, d);
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    logic       a;
    logic [7:0] b;
    logic       c;
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      step(1'b1, base + 8'(i), 1'b0, 1'b0, a, b, c, d);
      chk("push_ready", int'(c), 1);
    end
  endtask

  task automatic single_beat(input logic [7:0] v);
    logic       a;
    logic [7:0] b;
    logic       c;
    logic [3:0] d;
    int lat;
    lat = -1;
    step(1'b1, v, 1'b1, 1'b0, a, b, c, d);
    chk("sb_ready", int'(c), 1);
    chk("sb_cnt0", int'(d), 0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, a, b, c, d);
      if (k == 1) chk("sb_cnt1", int'(d), 1);
      if (a && lat < 0) begin
        lat = k;
        chk("sb_data", int'(b), int'(v));
      end
      if (k == 5) chk("sb_cnt_back0", int'(d), 0);
    end
    chk("sb_latency", lat, 4);
  endtask

  task automatic drain();
    logic       a;
    logic [7:0] b;
    logic       c;
    logic [3:0] d;
    for (int k = 0; k < 80; k++) begin
      if (q.size() == 0) break;
      step(1'b0, 8'h00, 1'b1, 1'b0, a, b, c, d);
    end
    chk("drained", q.size(), 0);
    idle(3, 1'b1);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    clear     = 1'b0;

    // Single beat, then fill to full and drain back-to-back.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    for (int i = 1; i <= 3; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hA5, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[6+i] = '{1'b1, 8'(i), 1'b0, i, (i >= 4), 8'h00, 1'b1};
    tbl[14] = '{1'b1, 8'h08, 1'b0, 8, 1'b1, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 8'h08, 1'b0, 8, 1'b1, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8, 1'b1, 8'h00, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[17+i] = '{1'b0, 8'h00, 1'b1, 8 - i, 1'b1, 8'(i), (i != 0)};
    tbl[25] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1};

    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].iv, tbl[i].id, tbl[i].ordy, 1'b0, s_ov, s_od, s_ir, s_cnt);
      chk($sformatf("tbl%0d_count", i), int'(s_cnt), tbl[i].ecnt);
      chk($sformatf("tbl%0d_out_valid", i), int'(s_ov), int'(tbl[i].eov));
      chk($sformatf("tbl%0d_in_ready", i), int'(s_ir), int'(tbl[i].eir));
      if (tbl[i].eov)
        chk($sformatf("tbl%0d_out_data", i), int'(s_od), int'(tbl[i].eod));
    end

    // Simultaneous push and pop at count 3.
    push_n(3, 8'h40);
    idle(6, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, s_ov, s_od, s_ir, s_cnt);
    chk("sim_ov", int'(s_ov), 1);
    chk("sim_ir", int'(s_ir), 1);
    chk("sim_cnt_before", int'(s_cnt), 3);
    step(1'b0, 8'h00, 1'b0, 1'b0, s_ov, s_od, s_ir, s_cnt);
    chk("sim_cnt_after", int'(s_cnt), 3);
    drain();

    // Streaming 40 beats with both sides always willing.
    begin
      int         sent;
      int         cyc;
      logic       prev_ir;
      logic [7:0] cur;
      sent    = 0;
      cyc     = 0;
      prev_ir = 1'b1;
      cur     = 8'($urandom);
      while (sent < 40 && cyc < 300) begin
        step(1'b1, cur, 1'b1, 1'b0, s_ov, s_od, s_ir, s_cnt);
        chk("stream_single_dip", int'(s_ir | prev_ir), 1);
        prev_ir = s_ir;
        if (s_ir) begin
          sent++;
          cur = 8'($urandom);
        end
        cyc++;
      end
      chk("stream_sent", sent, 40);
      drain();
    end

    // Clear with 5 stored and a read in flight.
    push_n(5, 8'h10);
    idle(6, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, s_ov, s_od, s_ir, s_cnt);
    step(1'b0, 8'h00, 1'b0, 1'b1, s_ov, s_od, s_ir, s_cnt);
    chk("clr_in_ready_low", int'(s_ir), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, s_ov, s_od, s_ir, s_cnt);
    chk("clr_count", int'(s_cnt), 0);
    chk("clr_out_valid", int'(s_ov), 0);
    chk("clr_in_ready", int'(s_ir), 1);
    single_beat(8'h3C);
    idle(4, 1'b1);

    // Async reset between edges with 6 stored.
    push_n(6, 8'h60);
    idle(4, 1'b0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    single_beat(8'h5A);

    // Random traffic: fill-biased phase, then drain-biased phase.
    for (int c = 0; c < 900; c++) begin
      logic iv;
      logic ordy;
      logic clr;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (c < 450) ? ($urandom_range(0, 3) == 0)
                       : ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 299) == 0);
      step(iv, 8'($urandom), ordy, clr, s_ov, s_od, s_ir, s_cnt);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
